// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter fed by the MMIO byte-write strobe.
// Bytes are queued in a FIFO and sent LSB first, framed 8N1. When the
// UART_TX_PARITY_EN macro is defined, an even-parity bit is added and the
// frame becomes 8E1. Every bit lasts BAUD_DIV clock cycles.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   tx_en       one-cycle write strobe; tx_data is sampled while it is high
//   tx_data     byte to enqueue
//   clr_ovf     one-cycle pulse that clears overflow
//   tx          serial line, registered, idles high
//   tx_busy     high while a frame is in flight or the FIFO is non-empty
//   fifo_full   FIFO holds FIFO_DEPTH entries
//   fifo_empty  FIFO holds 0 entries
//   fifo_level  current entry count, 0..FIFO_DEPTH
//   overflow    sticky flag: a write was dropped because the FIFO was full
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEVEL_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_en,
    input  logic [7:0]         tx_data,
    input  logic               clr_ovf,
    output logic               tx,
    output logic               tx_busy,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] PARITY = STATE_W'(4);
`else
    localparam int unsigned STATE_W = 2;
`endif
    localparam logic [STATE_W-1:0] IDLE  = STATE_W'(0);
    localparam logic [STATE_W-1:0] START = STATE_W'(1);
    localparam logic [STATE_W-1:0] DATA  = STATE_W'(2);
    localparam logic [STATE_W-1:0] STOP  = STATE_W'(3);

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic               pop;
    logic               push;
    logic               bit_end;
    logic               tx_d;
    logic [LEVEL_W-1:0] level_d;
    logic               ovf_d;

    // Fullness is judged on the registered count; a same-cycle pop never makes room.
    assign push    = tx_en && !fifo_full;
    assign bit_end = (cnt_q == '0);

    // Next-state, baud counter, shifter and FIFO bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? cnt_q : cnt_q - CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = RELOAD;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    cnt_d   = RELOAD;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = RELOAD;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                        cnt_d   = RELOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (pop) begin
            shift_d = mem[rd_ptr_q];
            par_d   = ^mem[rd_ptr_q];
        end

        // tx is driven from the next state so the pin is a clean register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        level_d = fifo_level + LEVEL_W'(push) - LEVEL_W'(pop);

        // Set wins over a same-cycle clear.
        ovf_d = overflow;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (tx_en && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            tx         <= tx_d;
            tx_busy    <= (state_d != IDLE) || (level_d != '0);
            fifo_full  <= (level_d == LEVEL_W'(FIFO_DEPTH));
            fifo_empty <= (level_d == '0);
            fifo_level <= level_d;
            overflow   <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// Runs the DUT with BAUD_DIV=4 and FIFO_DEPTH=4; frame length follows the
// UART_TX_PARITY_EN macro.
module tb_uart_tx_fifo;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FC = FB * BD;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       clr_ovf;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    uart_tx_fifo #(
        .BAUD_DIV   (4),
        .FIFO_DEPTH (4),
        .LEVEL_W    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .clr_ovf    (clr_ovf),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame bits in transmit order: start, d0..d7, [parity], stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Expected line level after edge j when frames from exp_q start at edge 1.
    function automatic logic exp_tx(input int j);
        logic [10:0] f;
        int k;
        int fr;
        if (j < 1) return 1'b1;
        k  = j - 1;
        fr = k / FC;
        if (fr >= exp_q.size()) return 1'b1;
        f = frame_bits(exp_q[fr]);
        return f[(k % FC) / BD];
    endfunction

    task automatic test_reset();
        rst = 1'b1; tx_en = 1'b0; tx_data = 8'h00; clr_ovf = 1'b0;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx got %b exp 1", tx); end
        n_checks++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
        n_checks++; if (fifo_full !== 1'b0)  begin n_fail++; $display("FAIL reset_full got %b exp 0", fifo_full); end
        n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_single_frame();
        exp_q = '{8'h55};
        for (int j = 0; j <= FC + 1; j++) begin
            tx_en   = (j == 0);
            tx_data = 8'h55;
            step();
            if (j == 0) begin
                n_checks++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b exp 0", fifo_empty); end
                n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", fifo_level); end
                n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL single_tx0 got %b exp 1", tx); end
            end
            if (j == 1) begin
                n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_pop_level got %0d exp 0", fifo_level); end
            end
            if (j >= 1) begin
                n_checks++; if (tx !== exp_tx(j)) begin n_fail++; $display("FAIL single_tx j=%0d got %b exp %b", j, tx, exp_tx(j)); end
            end
            if (j == FC) begin
                n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop got %b exp 1", tx_busy); end
            end
            if (j == FC + 1) begin
                n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b exp 0", tx_busy); end
            end
        end
        tx_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int peak;
        peak  = 0;
        exp_q = '{8'h01, 8'h80, 8'hFF};
        for (int j = 0; j <= 3 * FC + 1; j++) begin
            tx_en   = (j < 3);
            tx_data = (j < 3) ? exp_q[j] : 8'h00;
            step();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (j == 2) begin
                n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL b2b_level got %0d exp 2", fifo_level); end
            end
            if (j >= 1) begin
                n_checks++; if (tx !== exp_tx(j)) begin n_fail++; $display("FAIL b2b_tx j=%0d got %b exp %b", j, tx, exp_tx(j)); end
            end
            if (j == 3 * FC) begin
                n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_stop got %b exp 1", tx_busy); end
            end
            if (j == 3 * FC + 1) begin
                n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b exp 0", tx_busy); end
            end
        end
        n_checks++; if (peak != 2) begin n_fail++; $display("FAIL b2b_peak got %0d exp 2", peak); end
        tx_en = 1'b0;
    endtask

    task automatic test_overflow();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int j = 0; j <= 5 * FC + 1; j++) begin
            tx_en   = (j < 6);
            tx_data = 8'(17 * (j + 1));
            // Clear coincides with the dropping write at j=5 (set wins), then alone at j=6.
            clr_ovf = (j == 5) || (j == 6);
            step();
            if (j == 4) begin
                n_checks++; if (fifo_full !== 1'b1)  begin n_fail++; $display("FAIL ovf_full got %b exp 1", fifo_full); end
                n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
                n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL ovf_early got %b exp 0", overflow); end
            end
            if (j == 5) begin
                n_checks++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
                n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level_drop got %0d exp 4", fifo_level); end
            end
            if (j == 6) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow); end
            end
            if (j >= 1) begin
                n_checks++; if (tx !== exp_tx(j)) begin n_fail++; $display("FAIL ovf_tx j=%0d got %b exp %b", j, tx, exp_tx(j)); end
            end
            if (j == 5 * FC + 1) begin
                n_checks++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL ovf_busy_end got %b exp 0", tx_busy); end
                n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty_end got %b exp 1", fifo_empty); end
            end
        end
        tx_en = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_full_push_pop();
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int j = 0; j <= 5 * FC + 1; j++) begin
            tx_en   = (j < 5) || (j == FC + 1);
            tx_data = (j < 5) ? exp_q[j] : 8'hEE;
            step();
            if (j == FC) begin
                n_checks++; if (fifo_full !== 1'b1)  begin n_fail++; $display("FAIL fpp_full got %b exp 1", fifo_full); end
                n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fpp_level_pre got %0d exp 4", fifo_level); end
            end
            if (j == FC + 1) begin
                n_checks++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL fpp_ovf got %b exp 1", overflow); end
                n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL fpp_level_post got %0d exp 3", fifo_level); end
                n_checks++; if (fifo_full !== 1'b0)  begin n_fail++; $display("FAIL fpp_notfull got %b exp 0", fifo_full); end
            end
            if (j >= 1) begin
                n_checks++; if (tx !== exp_tx(j)) begin n_fail++; $display("FAIL fpp_tx j=%0d got %b exp %b", j, tx, exp_tx(j)); end
            end
        end
        tx_en   = 1'b0;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_clear got %b exp 0", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        exp_q = '{8'hA3, 8'h01, 8'h02};
        for (int j = 0; j <= 9; j++) begin
            tx_en   = (j < 3);
            tx_data = (j < 3) ? exp_q[j] : 8'h00;
            step();
            if (j >= 1) begin
                n_checks++; if (tx !== exp_tx(j)) begin n_fail++; $display("FAIL rstmid_tx j=%0d got %b exp %b", j, tx, exp_tx(j)); end
            end
        end
        tx_en = 1'b0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL rstmid_tx_abort got %b exp 1", tx); end
        n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got %b exp 1", fifo_empty); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level got %0d exp 0", fifo_level); end
        n_checks++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", tx_busy); end
        for (int j = 0; j < 3 * FC; j++) begin
            step();
            n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_quiet j=%0d got tx=%b busy=%b exp tx=1 busy=0", j, tx, tx_busy);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] vals [2];
        logic       par_exp [2];
        vals[0] = 8'h07;
        vals[1] = 8'h03;
`ifdef UART_TX_PARITY_EN
        par_exp[0] = 1'b1;
        par_exp[1] = 1'b0;
`else
        // Without parity the tenth bit slot is the stop bit.
        par_exp[0] = 1'b1;
        par_exp[1] = 1'b1;
`endif
        for (int v = 0; v < 2; v++) begin
            exp_q = '{vals[v]};
            for (int j = 0; j <= FC + 1; j++) begin
                tx_en   = (j == 0);
                tx_data = vals[v];
                step();
                if (j >= 1) begin
                    n_checks++; if (tx !== exp_tx(j)) begin n_fail++; $display("FAIL par_tx v=%0d j=%0d got %b exp %b", v, j, tx, exp_tx(j)); end
                end
                if (j == 1 + 9 * BD + 1) begin
                    n_checks++; if (tx !== par_exp[v]) begin n_fail++; $display("FAIL par_bit v=%0d got %b exp %b", v, tx, par_exp[v]); end
                end
                if (j == FC) begin
                    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL par_busy_stop v=%0d got %b exp 1", v, tx_busy); end
                end
                if (j == FC + 1) begin
                    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL par_len v=%0d got busy=%b exp 0", v, tx_busy); end
                end
            end
            tx_en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Serial UART transmitter that consumes the byte-write strobe issued by the MMIO register block (one-cycle tx_en plus 8-bit data) and drives the board TX pin.
Bytes are buffered in a small FIFO so the CPU can issue back-to-back stores without polling.
Each byte is framed 8N1, LSB first, at a fixed baud set by a clock divider.
Status outputs are returned to the MMIO read path so software can throttle writes.

Parameters:
BAUD_DIV, 868, clk cycles per serial bit (100 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.
LEVEL_W, 5, width of fifo_level; must equal log2(FIFO_DEPTH)+1.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
tx_en  in  1  one-cycle write strobe from the MMIO block.
tx_data  in  8  byte to send; sampled when tx_en=1.
clr_ovf  in  1  one-cycle pulse; clears overflow.
tx  out  1  serial line; idles high.
tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
fifo_empty  out  1  FIFO holds 0 entries.
fifo_level  out  LEVEL_W  current entry count, 0..FIFO_DEPTH.
overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset: tx=1, tx_busy=0, fifo_full=0, fifo_empty=1, fifo_level=0, overflow=0. FSM goes to IDLE; read/write pointers and baud counter go to 0.
- Reset during a frame aborts it; tx is 1 on the cycle after rst is sampled. Buffered bytes are discarded.
- Push:
  - tx_en=1 and fifo_full=0: write tx_data at the write pointer; pointer increments mod FIFO_DEPTH.
  - tx_en=1 and fifo_full=1: byte dropped, overflow set to 1 next cycle. fifo_full is judged on the registered count, so a same-cycle pop does not make room.
- Pop occurs only on FSM entry to START. The byte at the read pointer loads the shift register and the read pointer increments.
- Simultaneous push and pop: fifo_level unchanged, both pointers advance.
- overflow: clr_ovf clears it. If clr_ovf and a dropping push occur in the same cycle, overflow ends at 1 (set wins).
- Baud counter: loads BAUD_DIV-1 on every state entry and counts down. A bit period ends when the counter reaches 0, so every bit lasts exactly BAUD_DIV cycles.
- FSM:
  - IDLE: tx=1. If fifo_empty=0, pop and go to START.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx = shift[0]; shift right at each bit end. After bit index 7 ends, go to STOP (or PARITY, see below).
  - STOP: tx=1 for one bit period. At its end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: tx_en sampled at edge N into an empty FIFO with FSM in IDLE gives fifo_empty=0 after N, pop at N+1, tx=0 from N+1.
- tx is a registered output, glitch-free.
- tx_busy = (state != IDLE) or (fifo_empty == 0).
- fifo_full, fifo_empty and fifo_level are registered and consistent in the same cycle.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is held separately in LEVEL_W bits.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for one bit period, giving an 11-bit frame.
- Undefined: no PARITY state, giving a 10-bit frame (8N1). The state encoding omits PARITY.

Test Plan:
1. BAUD_DIV=4: reset, then tx_en with tx_data=0x55 -> tx=0 one cycle later, then bits 1,0,1,0,1,0,1,0, then 1. Each bit lasts 4 cycles; frame is 40 cycles; tx_busy falls after the stop bit.
2. Three consecutive tx_en of 0x01, 0x80, 0xFF -> fifo_level peaks at 2 (the first byte is popped immediately). Frames go out back-to-back with no idle cycles between stop and start; total 120 cycles at BAUD_DIV=4.
3. FIFO_DEPTH=4, FSM held in a long frame, 6 writes -> fifo_full=1 after 4 buffered, overflow=1 on the next cycle, and only the first 5 bytes are ever transmitted. clr_ovf pulse then sets overflow=0.
4. Assert rst mid-DATA of byte 0xA3 with 2 bytes queued -> tx=1 next cycle, fifo_empty=1, fifo_level=0, no further start bits.
5. With UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1 and an 11-bit frame. Send 0x03 -> parity bit 0. Undefined: both frames are 10 bits.
6. FIFO full with a push in the same cycle as a pop at a stop-to-start transition -> push dropped, overflow=1, fifo_level drops by 1.
